pipelined_shifter: RTL and testbench

Parametrised, pipelined successor to the combinational ALU shifter. It supports logical left/right, arithmetic right, and rotate left/right on a WIDTH-bit operand. A log2(WIDTH)-level barrel network is split across PIPE register stages. Valid/ready handshakes on both sides let it sit between the operand-issue logic and the ALU result mux with backpressure. A TAG sideband travels with each operation so the caller can match results to requests.

---
 rtl/pipelined_shifter.sv | 259 +++++++++++++++++++++++++
 tb/tb_pipelined_shifter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: WIDTH-bit barrel shifter (SHL/SHR/SHRA/ROL/ROR/pass) split
// over PIPE register stages with valid/ready handshakes and a TAG sideband.
// Optional build macro: SHIFTER_FLAGS_EN adds registered out_carry/out_zero.
module pipelined_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 8,
  parameter int unsigned PIPE  = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic             out_carry,
  output logic             out_zero
`endif
);

  localparam int unsigned L = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_SHL  = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHRA = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_PASS = 3'b101
  } op_e;

  // One barrel level: shift/rotate d by 2^j with the given fill bit.
  function automatic logic [WIDTH-1:0] level(input logic [WIDTH-1:0] d,
                                             input op_e op,
                                             input int unsigned j,
                                             input logic fill);
    int unsigned      s;
    logic [WIDTH-1:0] ones;
    s    = 32'd1 << j;
    ones = '1;
    case (op)
      OP_SHL:          level = d << s;
      OP_SHR, OP_SHRA: level = (d >> s) | ({WIDTH{fill}} & ~(ones >> s));
      OP_ROL:          level = (d << s) | (d >> (WIDTH - s));
      OP_ROR:          level = (d >> s) | (d << (WIDTH - s));
      default:         level = d;
    endcase
  endfunction

  // Stage input buses; index 0 is the pre-decoded request.
  logic             st_valid [PIPE];
  logic [WIDTH-1:0] st_data  [PIPE];
  logic [L-1:0]     st_amt   [PIPE];
  op_e              st_op    [PIPE];
  logic             st_over  [PIPE];
  logic             st_fill  [PIPE];
  logic [TAG_W-1:0] st_tag   [PIPE];
`ifdef SHIFTER_FLAGS_EN
  logic             st_carry [PIPE];
`endif

  logic             stall;
  op_e              pre_op;
  logic [L-1:0]     pre_amt;
  logic             pre_over;
  logic             pre_fill;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Pre-decode: normalise op, reduce amount to L bits, flag over-range shifts.
  always_comb begin
    pre_op   = OP_PASS;
    pre_amt  = '0;
    pre_over = 1'b0;
    pre_fill = 1'b0;
    case (in_op)
      3'b000:  pre_op = OP_SHL;
      3'b001:  pre_op = OP_SHR;
      3'b010:  pre_op = OP_SHRA;
      3'b011:  pre_op = OP_ROL;
      3'b100:  pre_op = OP_ROR;
      default: pre_op = OP_PASS;
    endcase
    if (pre_op != OP_PASS) pre_amt = in_amt[L-1:0];
    if (pre_op inside {OP_SHL, OP_SHR, OP_SHRA}) pre_over = (in_amt >= AMT_W'(WIDTH));
    if (pre_op == OP_SHRA) pre_fill = in_data[WIDTH-1];
  end

  assign st_valid[0] = in_valid;
  assign st_data[0]  = in_data;
  assign st_amt[0]   = pre_amt;
  assign st_op[0]    = pre_op;
  assign st_over[0]  = pre_over;
  assign st_fill[0]  = pre_fill;
  assign st_tag[0]   = in_tag;

`ifdef SHIFTER_FLAGS_EN
  logic [WIDTH-1:0] shl_sel;
  logic [WIDTH-1:0] shr_sel;
  logic             pre_carry;

  // Shift carry is taken from the raw amount here; rotate carry is derived from the result.
  always_comb begin
    shl_sel   = WIDTH'(1) << (AMT_W'(WIDTH) - in_amt);
    shr_sel   = WIDTH'(1) << (in_amt - AMT_W'(1));
    pre_carry = 1'b0;
    if (in_amt != '0 && in_amt <= AMT_W'(WIDTH)) begin
      if (pre_op == OP_SHL) pre_carry = |(in_data & shl_sel);
      else if (pre_op == OP_SHR || pre_op == OP_SHRA) pre_carry = |(in_data & shr_sel);
    end else if (in_amt > AMT_W'(WIDTH) && pre_op == OP_SHRA) begin
      pre_carry = in_data[WIDTH-1];
    end
  end

  assign st_carry[0] = pre_carry;
`endif

  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    localparam int unsigned LO = (k * L + PIPE - 1) / PIPE;
    localparam int unsigned HI = ((k + 1) * L + PIPE - 1) / PIPE;
    localparam int unsigned N  = HI - LO;

    logic [WIDTH-1:0] lv [N+1];
    logic             unused_amt;

    // Amount bits outside this stage's levels are carried but not consumed here.
    assign unused_amt = ^st_amt[k];
    assign lv[0]      = st_data[k];

    for (genvar j = 0; j < N; j++) begin : g_lvl
      assign lv[j+1] = st_amt[k][LO+j] ? level(lv[j], st_op[k], LO + j, st_fill[k]) : lv[j];
    end

    if (k < PIPE - 1) begin : g_mid
      logic             valid_d, valid_q;
      logic [WIDTH-1:0] data_d,  data_q;
      logic [L-1:0]     amt_d,   amt_q;
      op_e              op_d,    op_q;
      logic             over_d,  over_q;
      logic             fill_d,  fill_q;
      logic [TAG_W-1:0] tag_d,   tag_q;
`ifdef SHIFTER_FLAGS_EN
      logic             carry_d, carry_q;
`endif

      // Forward the partial result and its sideband to the next stage.
      always_comb begin
        valid_d = st_valid[k];
        data_d  = lv[N];
        amt_d   = st_amt[k];
        op_d    = st_op[k];
        over_d  = st_over[k];
        fill_d  = st_fill[k];
        tag_d   = st_tag[k];
`ifdef SHIFTER_FLAGS_EN
        carry_d = st_carry[k];
`endif
      end

      // Intermediate register; holds everything while the output is stalled.
      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          amt_q   <= '0;
          op_q    <= OP_SHL;
          over_q  <= 1'b0;
          fill_q  <= 1'b0;
          tag_q   <= '0;
`ifdef SHIFTER_FLAGS_EN
          carry_q <= 1'b0;
`endif
        end else if (!stall) begin
          valid_q <= valid_d;
          data_q  <= data_d;
          amt_q   <= amt_d;
          op_q    <= op_d;
          over_q  <= over_d;
          fill_q  <= fill_d;
          tag_q   <= tag_d;
`ifdef SHIFTER_FLAGS_EN
          carry_q <= carry_d;
`endif
        end
      end

      assign st_valid[k+1] = valid_q;
      assign st_data[k+1]  = data_q;
      assign st_amt[k+1]   = amt_q;
      assign st_op[k+1]    = op_q;
      assign st_over[k+1]  = over_q;
      assign st_fill[k+1]  = fill_q;
      assign st_tag[k+1]   = tag_q;
`ifdef SHIFTER_FLAGS_EN
      assign st_carry[k+1] = carry_q;
`endif
    end else begin : g_last
      logic             valid_d, valid_q;
      logic [WIDTH-1:0] data_d,  data_q;
      logic [TAG_W-1:0] tag_d,   tag_q;
`ifdef SHIFTER_FLAGS_EN
      logic             carry_d, carry_q;
      logic             zero_d,  zero_q;
`endif

      // Final result: over-range shifts collapse to the fill pattern.
      always_comb begin
        valid_d = st_valid[k];
        data_d  = st_over[k] ? {WIDTH{st_fill[k]}} : lv[N];
        tag_d   = st_tag[k];
`ifdef SHIFTER_FLAGS_EN
        carry_d = st_carry[k];
        if (st_op[k] == OP_ROL) carry_d = (st_amt[k] != '0) && data_d[0];
        if (st_op[k] == OP_ROR) carry_d = (st_amt[k] != '0) && data_d[WIDTH-1];
        zero_d  = (data_d == '0);
`endif
      end

      // Output register; stable while out_valid && !out_ready.
      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          tag_q   <= '0;
`ifdef SHIFTER_FLAGS_EN
          carry_q <= 1'b0;
          zero_q  <= 1'b0;
`endif
        end else if (!stall) begin
          valid_q <= valid_d;
          data_q  <= data_d;
          tag_q   <= tag_d;
`ifdef SHIFTER_FLAGS_EN
          carry_q <= carry_d;
          zero_q  <= zero_d;
`endif
        end
      end

      assign out_valid = valid_q;
      assign out_data  = data_q;
      assign out_tag   = tag_q;
`ifdef SHIFTER_FLAGS_EN
      assign out_carry = carry_q;
      assign out_zero  = zero_q;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: directed checks of pipelined_shifter (WIDTH=32, PIPE=2).
module tb_pipelined_shifter;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_amt;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
`ifdef SHIFTER_FLAGS_EN
  logic        out_carry;
  logic        out_zero;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] data;
    logic [7:0]  amt;
    logic [3:0]  tag;
    logic [31:0] exp;
    logic        c;
    logic        z;
  } vec_t;

  vec_t        vecs [18];
  logic [31:0] sexp [6];
  int          issued;
  int          drained;

  pipelined_shifter #(
    .WIDTH(32),
    .AMT_W(8),
    .PIPE (2),
    .TAG_W(4)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_op    (in_op),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
`ifdef SHIFTER_FLAGS_EN
    ,
    .out_carry(out_carry),
    .out_zero (out_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] d,
                       input logic [7:0] amt, input logic [3:0] tag);
    in_valid = v;
    in_op    = op;
    in_data  = d;
    in_amt   = amt;
    in_tag   = tag;
  endtask

  // Issue one op, check it is absent after 1 cycle and present after 2, then drain it.
  task automatic run_op(input vec_t v);
    drive(1'b1, v.op, v.data, v.amt, v.tag);
    tick();
    in_valid = 1'b0;
    chk({v.name, " early valid"}, out_valid, 1'b0);
    tick();
    chk({v.name, " valid"}, out_valid, 1'b1);
    chk({v.name, " data"}, out_data, v.exp);
    chk({v.name, " tag"}, out_tag, v.tag);
`ifdef SHIFTER_FLAGS_EN
    chk({v.name, " carry"}, out_carry, v.c);
    chk({v.name, " zero"}, out_zero, v.z);
`endif
    tick();
  endtask

  initial begin
    //           name         op      data          amt  tag  expected      c     z
    vecs[0]  = '{"shl4",     3'b000, 32'h00000001,   4,  3, 32'h00000010, 1'b0, 1'b0};
    vecs[1]  = '{"shra31",   3'b010, 32'h80000000,  31,  1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[2]  = '{"shra200",  3'b010, 32'h80000000, 200,  2, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[3]  = '{"shr40",    3'b001, 32'hFFFFFFFF,  40,  4, 32'h00000000, 1'b0, 1'b1};
    vecs[4]  = '{"ror33",    3'b100, 32'h00000001,  33,  5, 32'h80000000, 1'b1, 1'b0};
    vecs[5]  = '{"rol32",    3'b011, 32'h12345678,  32,  6, 32'h12345678, 1'b0, 1'b0};
    vecs[6]  = '{"pass110",  3'b110, 32'hDEADBEEF,   5,  7, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[7]  = '{"shl_c",    3'b000, 32'h80000001,   1,  8, 32'h00000002, 1'b1, 1'b0};
    vecs[8]  = '{"shr_c",    3'b001, 32'h00000001,   1,  9, 32'h00000000, 1'b1, 1'b1};
    vecs[9]  = '{"shl32",    3'b000, 32'h00000001,  32, 10, 32'h00000000, 1'b1, 1'b1};
    vecs[10] = '{"shr0",     3'b001, 32'h12345678,   0, 11, 32'h12345678, 1'b0, 1'b0};
    vecs[11] = '{"shra40p",  3'b010, 32'h7FFFFFFF,  40, 12, 32'h00000000, 1'b0, 1'b1};
    vecs[12] = '{"rol4",     3'b011, 32'h80000001,   4, 13, 32'h00000018, 1'b0, 1'b0};
    vecs[13] = '{"shr4",     3'b001, 32'hF0F0F0F0,   4, 14, 32'h0F0F0F0F, 1'b0, 1'b0};
    vecs[14] = '{"shra4",    3'b010, 32'h80000000,   4, 15, 32'hF8000000, 1'b0, 1'b0};
    vecs[15] = '{"ror8",     3'b100, 32'h12345678,   8,  0, 32'h78123456, 1'b0, 1'b0};
    vecs[16] = '{"shr32",    3'b001, 32'h80000000,  32,  1, 32'h00000000, 1'b1, 1'b1};
    vecs[17] = '{"shl31",    3'b000, 32'h00000003,  31,  2, 32'h80000000, 1'b1, 1'b0};

    // 0xA5 << 3*i for tags 0..5
    sexp[0] = 32'h000000A5;
    sexp[1] = 32'h00000528;
    sexp[2] = 32'h00002940;
    sexp[3] = 32'h00014A00;
    sexp[4] = 32'h000A5000;
    sexp[5] = 32'h00528000;

    clr_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 8'd0, 4'd0);
    #2 clr_n = 1'b0;
    tick();
    tick();
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_data", out_data, 32'h0);
    chk("reset out_tag", out_tag, 4'h0);
    chk("reset in_ready", in_ready, 1'b1);
    clr_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) run_op(vecs[i]);

    // Back-to-back tags 0..5 with out_ready low in cycles 3..5.
    issued  = 0;
    drained = 0;
    for (int c = 0; c < 20; c++) begin
      drive(issued < 6, 3'b000, 32'h000000A5, 8'(3 * issued), 4'(issued));
      out_ready = !(c >= 3 && c <= 5);
      #3;
      if (c < 9) chk("stall in_ready", in_ready, !(c >= 3 && c <= 5));
      if (out_valid) begin
        if (drained < 6) begin
          chk("stall tag", out_tag, 4'(drained));
          chk("stall data", out_data, sexp[drained]);
        end else begin
          chk("stall duplicate", out_valid, 1'b0);
        end
        if (out_ready) drained++;
      end
      if (in_valid && in_ready) issued++;
      tick();
    end
    chk("stall issued", issued, 6);
    chk("stall drained", drained, 6);
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset with two ops in flight.
    drive(1'b1, 3'b000, 32'h00000001, 8'd1, 4'd7);
    tick();
    drive(1'b1, 3'b000, 32'h00000001, 8'd2, 4'd8);
    tick();
    in_valid = 1'b0;
    chk("pre-reset valid", out_valid, 1'b1);
    chk("pre-reset tag", out_tag, 4'd7);
    clr_n = 1'b0;
    #1;
    chk("async clr out_valid", out_valid, 1'b0);
    chk("async clr out_data", out_data, 32'h0);
    chk("async clr out_tag", out_tag, 4'h0);
    tick();
    clr_n = 1'b1;
    tick();
    chk("no stale 1", out_valid, 1'b0);
    tick();
    chk("no stale 2", out_valid, 1'b0);
    run_op('{"post-reset", 3'b100, 32'h000000F0, 8'd4, 4'd9, 32'h0000000F, 1'b0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
